// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bridge: region codes, GPIO register
// selects and the bridge FSM state encoding.
package mio_pkg;

  localparam logic [3:0] REG_GPIO = 4'hF;
  localparam logic [3:0] REG_CNT  = 4'hE;

  localparam logic GPIO_SW  = 1'b0;
  localparam logic GPIO_LED = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RAM_ACC,
    RAM_WAIT,
    RESP
  } mio_state_t;

  function automatic logic is_ram_region(input logic [3:0] region);
    return (region != REG_GPIO) && (region != REG_CNT);
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit counter; a load replaces the value and counting
// resumes from it on the following edge.
module mio_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] cnt
);

  logic [31:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/mio_bridge.sv
// CPU memory/IO bridge: decodes each request to block RAM, GPIO or the
// counter, inserts RAM wait states and returns data with a MIO_ready pulse.
module mio_bridge
  import mio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1,
  parameter int LED_W   = 8,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic [31:0]       cnt_out
);

  localparam logic [2:0] WAIT_INIT = 3'(RAM_LAT - 1);

  mio_state_t        state_reg, state_next;
  logic [3:0]        region_reg, region_next;
  logic [RAM_AW-1:0] word_reg, word_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic [31:0]       data_reg, data_next;
  logic [2:0]        wait_reg, wait_next;
  logic [LED_W-1:0]  led_reg, led_next;
  logic              cnt_load;
  logic [3:0]        req_region;
  logic [31:0]       gpio_rdata;
  logic              unused_addr_bits;

  assign req_region       = Addr_out[31:28];
  assign gpio_rdata       = (Addr_out[2] == GPIO_LED) ? 32'(led_reg) : 32'(sw_in);
  assign unused_addr_bits = ^{Addr_out[27:RAM_AW+2], Addr_out[1:0]};

  mio_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (Data_out),
    .cnt      (cnt_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      region_reg <= '0;
      word_reg   <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      data_reg   <= '0;
      wait_reg   <= '0;
      led_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      region_reg <= region_next;
      word_reg   <= word_next;
      wdata_reg  <= wdata_next;
      we_reg     <= we_next;
      data_reg   <= data_next;
      wait_reg   <= wait_next;
      led_reg    <= led_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    region_next = region_reg;
    word_next   = word_reg;
    wdata_next  = wdata_reg;
    we_next     = we_reg;
    data_next   = data_reg;
    wait_next   = wait_reg;
    led_next    = led_reg;
    cnt_load    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (CPU_MIO) begin
          region_next = req_region;
          word_next   = Addr_out[RAM_AW+1:2];
          wdata_next  = Data_out;
          we_next     = mem_w;
          data_next   = '0;
          // Peripherals complete on this edge; RAM needs its own enable cycle.
          if (req_region == REG_GPIO) begin
            state_next = RESP;
            if (!mem_w) begin
              data_next = gpio_rdata;
            end else if (Addr_out[2] == GPIO_LED) begin
              led_next = Data_out[LED_W-1:0];
            end
          end else if (req_region == REG_CNT) begin
            state_next = RESP;
            if (!mem_w) begin
              data_next = cnt_out;
            end else begin
              cnt_load = 1'b1;
            end
          end else begin
            state_next = RAM_ACC;
          end
        end
      end
      RAM_ACC: begin
        wait_next  = WAIT_INIT;
        state_next = (RAM_LAT == 1) ? RESP : RAM_WAIT;
      end
      RAM_WAIT: begin
        wait_next = wait_reg - 3'd1;
        if (wait_reg <= 3'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign MIO_ready = (state_reg == RESP);
  assign ram_en    = (state_reg == RAM_ACC);
  assign ram_we    = ram_en & we_reg;
  assign ram_addr  = word_reg;
  assign ram_din   = wdata_reg;
  assign led_out   = led_reg;

  // RAM read data only becomes valid in the response cycle, so it is steered
  // straight through rather than captured one edge early.
  assign Data_in = (MIO_ready && is_ram_region(region_reg) && !we_reg) ? ram_dout : data_reg;

endmodule

// File: doc/mio_bridge.md
Name: mio_bridge

Overview:
- Memory/IO bridge directly downstream of the SCPU core.
- Consumes the CPU's bus request (CPU_MIO, mem_w, Addr_out, Data_out) and returns read data on Data_in with a one-cycle MIO_ready completion pulse.
- Decodes each access to one of three targets: synchronous block RAM, GPIO (switches/LEDs), or a free-running 32-bit counter.
- Inserts RAM wait states so the CPU can stall on MIO_ready.

Parameters:
- RAM_AW, 10: RAM word-address width (4 KiB RAM).
- RAM_LAT, 1: RAM read latency in cycles, from ram_en to ram_dout valid; legal range 1..7.
- LED_W, 8: width of the LED output register.
- SW_W, 16: width of the switch input.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- CPU_MIO  in  1  CPU access request; held high until MIO_ready.
- mem_w  in  1  1 = write, 0 = read; valid while CPU_MIO = 1.
- Addr_out  in  32  CPU byte address.
- Data_out  in  32  CPU write data.
- Data_in  out  32  read data to the CPU; valid while MIO_ready = 1.
- MIO_ready  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM enable; one-cycle pulse.
- ram_we  out  1  RAM write enable; qualified by ram_en.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data.
- sw_in  in  SW_W  switch inputs; already synchronised upstream.
- led_out  out  LED_W  LED register.
- cnt_out  out  32  current counter value, for display.

Behaviour:
- Address decode, on latched Addr_out[31:28]:
  - 4'hF: GPIO.
  - 4'hE: counter.
  - any other value: RAM.
- RAM addressing:
  - ram_addr = Addr_out[RAM_AW+1:2].
  - Byte offset bits [1:0] are ignored.
  - Upper address bits are ignored, so RAM accesses alias.
- FSM states: IDLE, RAM_ACC, RAM_WAIT, RESP.
- IDLE:
  - If CPU_MIO = 1, latch addr, wdata and mem_w.
  - Peripheral target: perform the access this edge and go to RESP.
  - RAM target: go to RAM_ACC.
- RAM_ACC:
  - ram_en = 1, ram_we = latched mem_w, ram_addr/ram_din from latches.
  - Load wait counter with RAM_LAT-1.
  - If RAM_LAT = 1, go to RESP; otherwise go to RAM_WAIT.
- RAM_WAIT: decrement wait counter each cycle; go to RESP when it reaches 0.
- RESP:
  - On entry, Data_in is registered: ram_dout for RAM reads, peripheral value for peripheral reads, 0 for writes.
  - MIO_ready = 1 for exactly this cycle, then return to IDLE.
- Latency, with the request first seen in IDLE at cycle N:
  - Peripheral access: MIO_ready at N+1.
  - RAM access: ram_en at N+1, MIO_ready at N+1+RAM_LAT.
- Back-to-back requests: CPU_MIO still high in IDLE after RESP is a new request. Minimum spacing is 2 cycles for peripherals and RAM_LAT+2 cycles for RAM.
- CPU_MIO dropping while the bridge is not in IDLE is ignored; the latched access completes and MIO_ready still pulses.
- GPIO, Addr_out[2] selects the register:
  - Addr_out[2] = 0: read returns zero-extended sw_in; write is ignored but still completes.
  - Addr_out[2] = 1: read returns zero-extended led_out; write loads led_out <= Data_out[LED_W-1:0].
- Counter:
  - Increments by 1 every cycle; wraps from FFFF_FFFF to 0.
  - A write loads Data_out, and the next cycle continues from Data_out+1.
  - A read returns the value before that edge's increment.
- Reset (reset = 0 at an edge), including mid-operation:
  - State returns to IDLE and any in-flight access is dropped.
  - No MIO_ready is produced for the dropped access.
  - MIO_ready = 0, ram_en = 0, ram_we = 0, Data_in = 0, led_out = 0, counter = 0.
  - ram_addr and ram_din = 0.
- ram_en and ram_we are never high outside RAM_ACC.

Decomposition:
- Shared package mio_pkg holds:
  - region codes REG_GPIO = 4'hF, REG_CNT = 4'hE.
  - FSM state enum.
  - GPIO sub-address constants.
- One sub-module, mio_counter: the 32-bit free-running counter with load port.
- Decode and FSM stay in mio_bridge.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with CPU_MIO = 1 → MIO_ready, ram_en and led_out stay 0; cnt_out = 0 on release.
- RAM write then read, RAM_LAT = 1:
  - Write 0xDEADBEEF to 0x0000_0010 → ram_en/ram_we at N+1, ram_addr = 4, MIO_ready at N+2.
  - Read of the same address → Data_in = 0xDEADBEEF with MIO_ready.
- RAM_LAT = 3 read → exactly 2 RAM_WAIT cycles, MIO_ready at N+4, single ram_en pulse.
- GPIO:
  - sw_in = 16'hA5A5; read 0xF000_0000 → Data_in = 0x0000A5A5 at N+1.
  - Write 0x1FF to 0xF000_0004 → led_out = 8'hFF.
  - Read back 0xF000_0004 → 0x000000FF.
- Counter: write 0xFFFF_FFFE to 0xE000_0000 → cnt_out = 0xFFFF_FFFE, then 0xFFFF_FFFF, then wraps to 0.
- Reset asserted during RAM_WAIT (RAM_LAT = 3) → no MIO_ready.
- After release with CPU_MIO held high, a fresh access completes normally.
